// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction: conditional two's-complement negation of the
// 2*WIDTH product, or of the quotient and remainder independently.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic             neg_main,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg;
  logic [WIDTH-1:0]   rem_neg;

  assign prod     = {hi_in, lo_in};
  assign prod_neg = ~prod + (2*WIDTH)'(1);
  assign quot_neg = ~lo_in + WIDTH'(1);
  assign rem_neg  = ~hi_in + WIDTH'(1);

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    if (is_div) begin
      lo_out = neg_main ? quot_neg : lo_in;
      hi_out = neg_rem ? rem_neg : hi_in;
    end else begin
      {hi_out, lo_out} = neg_main ? prod_neg : prod;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide engine sharing one WIDTH+1-bit
// adder/subtractor; start/busy/done handshake with abort and divide-by-zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_reg, state_next;
  op_e              op_reg;
  logic             sign_a_reg, sign_b_reg, dz_reg;
  logic [WIDTH-1:0] opnd_reg, acc_hi_reg, acc_lo_reg, hi_reg, lo_reg;
  logic [CW-1:0]    count_reg;

  op_e              op_in;
  logic             in_signed, in_div, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? (~a + ONE) : a;
  assign b_mag     = b_neg ? (~b + ONE) : b;
  assign b_zero    = (b == '0);

  // Shared adder: add for shift-add multiply, subtract (carry = no borrow) for divide.
  logic [WIDTH:0]   add_x, add_y;
  logic             add_sub;
  logic [WIDTH+1:0] add_full;

  always_comb begin
    add_x   = {1'b0, acc_hi_reg};
    add_y   = acc_lo_reg[0] ? {1'b0, opnd_reg} : '0;
    add_sub = 1'b0;
    if (op_is_div(op_reg)) begin
      add_x   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
      add_y   = {1'b0, opnd_reg};
      add_sub = 1'b1;
    end
  end

  assign add_full = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
                  + {{(WIDTH+1){1'b0}}, add_sub};

  logic [WIDTH-1:0] iter_hi, iter_lo;

  always_comb begin
    iter_hi = add_full[WIDTH:1];
    iter_lo = {add_full[0], acc_lo_reg[WIDTH-1:1]};
    if (op_is_div(op_reg)) begin
      if (add_full[WIDTH+1]) begin
        iter_hi = add_full[WIDTH-1:0];
        iter_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = add_x[WIDTH-1:0];
        iter_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [WIDTH-1:0] fix_hi, fix_lo;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div   (op_is_div(op_reg)),
    .neg_main (sign_a_reg ^ sign_b_reg),
    .neg_rem  (sign_a_reg),
    .hi_in    (acc_hi_reg),
    .lo_in    (acc_lo_reg),
    .hi_out   (fix_hi),
    .lo_out   (fix_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (in_div && b_zero) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (count_reg == '0) begin
          state_next = S_FIX;
        end
      end
      S_FIX:   state_next = abort ? S_IDLE : S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != S_IDLE);
    done    = (state_reg == S_DONE);
    divzero = (state_reg == S_DONE) && dz_reg;
  end

  // Operand latch, iteration registers and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= OP_MULT;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      dz_reg     <= 1'b0;
      opnd_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg     <= op_in;
            sign_a_reg <= a_neg;
            sign_b_reg <= b_neg;
            dz_reg     <= in_div & b_zero;
            opnd_reg   <= in_div ? b_mag : a_mag;
            acc_hi_reg <= '0;
            acc_lo_reg <= in_div ? a_mag : b_mag;
            count_reg  <= CW'(WIDTH - 1);
          end
        end
        S_RUN: begin
          if (!abort) begin
            acc_hi_reg <= iter_hi;
            acc_lo_reg <= iter_lo;
            count_reg  <= count_reg - CW'(1);
          end
        end
        S_FIX: begin
          if (!abort) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule
